// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises N cache-side memory ports onto one shared backing
// memory port. Round-robin arbitration by default; define ARB_FIXED_PRIO_EN
// for fixed priority (lowest channel index always wins).
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   ch_rw_flag/addr/write_data/write_mask   per-channel request (slice i = channel i)
//   ch_read_data             last read result per channel
//   ch_busy                  arbiter occupied (REQ or DONE)
//   ch_done                  one-cycle completion pulse for the granted channel
//   mem_rw_flag/addr/write_data/write_mask  downstream request
//   mem_read_data, mem_busy, mem_done       downstream response
module mem_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2*NUM_CH-1:0]            ch_rw_flag,
  input  logic [ADDR_W*NUM_CH-1:0]       ch_addr,
  input  logic [DATA_W*NUM_CH-1:0]       ch_write_data,
  input  logic [(DATA_W/8)*NUM_CH-1:0]   ch_write_mask,
  output logic [DATA_W*NUM_CH-1:0]       ch_read_data,
  output logic [NUM_CH-1:0]              ch_busy,
  output logic [NUM_CH-1:0]              ch_done,
  output logic [1:0]                     mem_rw_flag,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_write_data,
  output logic [DATA_W/8-1:0]            mem_write_mask,
  input  logic [DATA_W-1:0]              mem_read_data,
  input  logic                           mem_busy,
  input  logic                           mem_done
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Per-channel views of the flattened request buses.
  logic [1:0]        flag_a  [NUM_CH];
  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [DATA_W-1:0] wdata_a [NUM_CH];
  logic [MASK_W-1:0] mask_a  [NUM_CH];
  logic [DATA_W-1:0] rd_q    [NUM_CH];
  logic [DATA_W-1:0] rd_d    [NUM_CH];
  logic [NUM_CH-1:0] req_valid;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign flag_a[i]  = ch_rw_flag[2*i +: 2];
    assign addr_a[i]  = ch_addr[ADDR_W*i +: ADDR_W];
    assign wdata_a[i] = ch_write_data[DATA_W*i +: DATA_W];
    assign mask_a[i]  = ch_write_mask[MASK_W*i +: MASK_W];
    // Only 01 and 10 are requests; 00 and 11 are idle.
    assign req_valid[i] = ^flag_a[i];
    assign ch_read_data[DATA_W*i +: DATA_W] = rd_q[i];
  end

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  grant_q, grant_d;
  logic [1:0]        flag_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [MASK_W-1:0] mask_d;
  logic [NUM_CH-1:0] busy_d, done_d;
  logic [PTR_W-1:0]  start;
  logic              complete;

  // Downstream completion: done with no backpressure in the same cycle.
  assign complete = (state_q == ST_REQ) && mem_done && !mem_busy;

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: search always begins at channel 0.
  assign start = '0;
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;

  assign start = ptr_q;

  // Pointer moves past the channel just served.
  always_comb begin
    ptr_d = ptr_q;
    if (complete) begin
      ptr_d = (32'(grant_q) == NUM_CH - 1) ? '0 : PTR_W'(32'(grant_q) + 32'd1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
`endif

  // Arbitration: first valid channel at or above start, with wrap-around.
  logic              any_req;
  logic [PTR_W-1:0]  win;
  logic [PTR_W-1:0]  arb_idx;
  int unsigned       arb_sum;

  always_comb begin
    any_req = 1'b0;
    win     = '0;
    arb_idx = '0;
    arb_sum = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      arb_sum = 32'(start) + k;
      if (arb_sum >= NUM_CH) arb_sum = arb_sum - NUM_CH;
      arb_idx = PTR_W'(arb_sum);
      if (!any_req && req_valid[arb_idx]) begin
        any_req = 1'b1;
        win     = arb_idx;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    flag_d  = mem_rw_flag;
    addr_d  = mem_addr;
    wdata_d = mem_write_data;
    mask_d  = mem_write_mask;
    rd_d    = rd_q;
    done_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = win;
          flag_d  = flag_a[win];
          addr_d  = addr_a[win];
          wdata_d = wdata_a[win];
          mask_d  = mask_a[win];
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (complete) begin
          flag_d = 2'b00;
          if (mem_rw_flag == 2'b01) rd_d[grant_q] = mem_read_data;
          done_d[grant_q] = 1'b1;
          state_d = ST_DONE;
        end
      end
      // The finished master still holds its request here, so it is ignored.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_IDLE) ? '0 : '1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      mem_rw_flag    <= 2'b00;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_write_mask <= '0;
      rd_q           <= '{default: '0};
      ch_busy        <= '0;
      ch_done        <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      mem_rw_flag    <= flag_d;
      mem_addr       <= addr_d;
      mem_write_data <= wdata_d;
      mem_write_mask <= mask_d;
      rd_q           <= rd_d;
      ch_busy        <= busy_d;
      ch_done        <= done_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (NUM_CH=2) with a
// transaction-level reference model, a behavioural backing memory and
// randomized masters/backpressure. Honours ARB_FIXED_PRIO_EN if defined.
module tb_mem_arbiter;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [2*NUM_CH-1:0]          ch_rw_flag;
  logic [ADDR_W*NUM_CH-1:0]     ch_addr;
  logic [DATA_W*NUM_CH-1:0]     ch_write_data;
  logic [MASK_W*NUM_CH-1:0]     ch_write_mask;
  logic [DATA_W*NUM_CH-1:0]     ch_read_data;
  logic [NUM_CH-1:0]            ch_busy;
  logic [NUM_CH-1:0]            ch_done;
  logic [1:0]                   mem_rw_flag;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_write_data;
  logic [MASK_W-1:0]            mem_write_mask;
  logic [DATA_W-1:0]            mem_read_data;
  logic                         mem_busy;
  logic                         mem_done;

  mem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ch_rw_flag(ch_rw_flag), .ch_addr(ch_addr),
    .ch_write_data(ch_write_data), .ch_write_mask(ch_write_mask),
    .ch_read_data(ch_read_data), .ch_busy(ch_busy), .ch_done(ch_done),
    .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_write_mask(mem_write_mask),
    .mem_read_data(mem_read_data), .mem_busy(mem_busy), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  // Master-side drive state.
  logic [1:0]  flag_r  [NUM_CH];
  logic [31:0] addr_r  [NUM_CH];
  logic [31:0] wdata_r [NUM_CH];
  logic [3:0]  mask_r  [NUM_CH];
  bit          act     [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_rw_flag[2*i +: 2]           = flag_r[i];
      ch_addr[ADDR_W*i +: ADDR_W]    = addr_r[i];
      ch_write_data[DATA_W*i +: DATA_W] = wdata_r[i];
      ch_write_mask[MASK_W*i +: MASK_W] = mask_r[i];
    end
  end

  // Reference model state.
  int          m_phase;   // 0 arbiter free, 1 transaction outstanding, 2 completion cycle
  int          m_ptr;
  int          m_grant;
  logic [1:0]  m_flag;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_mask;
  logic [31:0] m_rd [NUM_CH];
  logic [31:0] mem_model [16];

  logic [1:0]  p_flag  [NUM_CH];
  logic [31:0] p_addr  [NUM_CH];
  logic [31:0] p_wdata [NUM_CH];
  logic [3:0]  p_mask  [NUM_CH];
  logic        p_busy, p_done;
  logic [31:0] p_rdata;

  int done_log[$];
  int obs_done [NUM_CH];
  bit rand_en, noise_en, rand_slave, auto_rereq;
  int stall_left;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Winner among the requests presented at the last edge.
  function automatic int pick();
    for (int k = 0; k < NUM_CH; k++) begin
      int i;
`ifdef ARB_FIXED_PRIO_EN
      i = k;
`else
      i = (m_ptr + k) % NUM_CH;
`endif
      if (p_flag[i] == 2'b01 || p_flag[i] == 2'b10) return i;
    end
    return -1;
  endfunction

  task automatic issue(input int ch, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    act[ch] = 1'b1; flag_r[ch] = f; addr_r[ch] = a; wdata_r[ch] = d; mask_r[ch] = m;
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_grant = 0; m_flag = 2'b00;
    m_addr = '0; m_wdata = '0; m_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_rd[i] = '0; act[i] = 1'b0; flag_r[i] = 2'b00;
      addr_r[i] = '0; wdata_r[i] = '0; mask_r[i] = '0;
    end
  endtask

  // One clock: advance the model over the edge, compare, then drive new inputs.
  task automatic step();
    int w, done_ch;
    logic [63:0] rd_pack;
    for (int i = 0; i < NUM_CH; i++) begin
      p_flag[i] = flag_r[i]; p_addr[i] = addr_r[i];
      p_wdata[i] = wdata_r[i]; p_mask[i] = mask_r[i];
    end
    p_busy = mem_busy; p_done = mem_done; p_rdata = mem_read_data;
    @(posedge clk); #1;
    done_ch = -1;
    case (m_phase)
      0: begin
        w = pick();
        if (w >= 0) begin
          m_grant = w; m_flag = p_flag[w]; m_addr = p_addr[w];
          m_wdata = p_wdata[w]; m_mask = p_mask[w]; m_phase = 1;
        end
      end
      1: begin
        if (p_done && !p_busy) begin
          if (m_flag == 2'b01) m_rd[m_grant] = p_rdata;
          else mem_model[m_addr[5:2]] = merge(mem_model[m_addr[5:2]], m_wdata, m_mask);
          m_ptr = (m_grant + 1) % NUM_CH;
          m_phase = 2;
          done_ch = m_grant;
        end
      end
      default: m_phase = 0;
    endcase
    rd_pack = '0;
    for (int i = 0; i < NUM_CH; i++) rd_pack[32*i +: 32] = m_rd[i];
    check("busy",     64'(ch_busy), (m_phase != 0) ? 64'({NUM_CH{1'b1}}) : 64'd0);
    check("mem_flag", 64'(mem_rw_flag), (m_phase == 1) ? 64'(m_flag) : 64'd0);
    check("mem_addr", 64'(mem_addr), 64'(m_addr));
    check("mem_data", 64'(mem_write_data), 64'(m_wdata));
    check("mem_mask", 64'(mem_write_mask), 64'(m_mask));
    check("done",     64'(ch_done), (done_ch >= 0) ? (64'd1 << done_ch) : 64'd0);
    check("rd_data",  64'(ch_read_data), rd_pack);
    for (int i = 0; i < NUM_CH; i++) obs_done[i] += int'(ch_done[i]);
    if (done_ch >= 0) begin
      done_log.push_back(done_ch);
      act[done_ch] = 1'b0;
      flag_r[done_ch] = 2'b00;
      if (auto_rereq) issue(done_ch, 2'b01, addr_r[done_ch], 32'h0, 4'h0);
    end
    if (rand_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!act[i]) begin
          if ($urandom % 4 == 0)
            issue(i, ($urandom % 2 == 0) ? 2'b01 : 2'b10, {20'($urandom), 10'($urandom), 2'b00},
                  $urandom, 4'($urandom));
          else if (noise_en)
            flag_r[i] = ($urandom % 2 == 0) ? 2'b11 : 2'b00;
        end
      end
    end
    if (rand_slave) begin
      mem_busy = ($urandom % 3 == 0);
      mem_done = ($urandom % 2 == 0);
    end else if (m_phase == 1 && stall_left > 0) begin
      mem_busy = 1'b1; mem_done = 1'b0; stall_left--;
    end else begin
      mem_busy = 1'b0; mem_done = 1'b1;
    end
    mem_read_data = (mem_rw_flag == 2'b01) ? mem_model[mem_addr[5:2]] : $urandom;
  endtask

  task automatic drain();
    int n, pend;
    n = 0;
    pend = 1;
    while (pend != 0 && n < 200) begin
      pend = (m_phase != 0) ? 1 : 0;
      for (int i = 0; i < NUM_CH; i++) if (act[i]) pend++;
      if (pend != 0) begin step(); n++; end
    end
    check("drain_pending", 64'(pend), 64'd0);
  endtask

  int n, c0, c1, exp_ch;

  initial begin
    rst = 1'b0;
    rand_en = 0; noise_en = 0; rand_slave = 0; auto_rereq = 0; stall_left = 0;
    mem_busy = 1'b0; mem_done = 1'b1; mem_read_data = '0;
    for (int i = 0; i < NUM_CH; i++) obs_done[i] = 0;
    for (int i = 0; i < 16; i++) mem_model[i] = 32'h01010101 * 32'(i);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(ch_busy), 64'd0);
    check("rst_done", 64'(ch_done), 64'd0);
    check("rst_flag", 64'(mem_rw_flag), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_rd",   64'(ch_read_data), 64'd0);
    @(negedge clk) rst = 1'b1;

    // Single read, zero-wait memory.
    mem_model[0] = 32'hDEADBEEF;
    issue(0, 2'b01, 32'h100, 32'h0, 4'h0);
    step();
    check("rd_issue_c1", 64'(mem_rw_flag), 64'h1);
    step();
    check("rd_done_c2", 64'(ch_done), 64'h1);
    check("rd_data_c2", 64'(ch_read_data[31:0]), 64'hDEADBEEF);
    step(); step();
    check("rd_held", 64'(ch_read_data[31:0]), 64'hDEADBEEF);

    // Masked write on channel 1.
    c1 = obs_done[1];
    issue(1, 2'b10, 32'h40, 32'h12345678, 4'b0011);
    step();
    check("wr_flag", 64'(mem_rw_flag), 64'h2);
    check("wr_addr", 64'(mem_addr), 64'h40);
    check("wr_data", 64'(mem_write_data), 64'h12345678);
    check("wr_mask", 64'(mem_write_mask), 64'h3);
    repeat (4) step();
    check("wr_done_once", 64'(obs_done[1] - c1), 64'd1);
    check("wr_rd_unchanged", 64'(ch_read_data[63:32]), 64'd0);
    issue(0, 2'b01, 32'h40, 32'h0, 4'h0);
    repeat (3) step();
    check("rd_after_wr", 64'(ch_read_data[31:0]), 64'hDEAD5678);
    drain();

    // Continuous contention (pointer now at channel 1).
    done_log.delete();
    auto_rereq = 1;
    issue(0, 2'b01, 32'h80, 32'h0, 4'h0);
    issue(1, 2'b01, 32'hC0, 32'h0, 4'h0);
    repeat (14) step();
    auto_rereq = 0;
    check("rr_count", 64'(done_log.size() >= 4), 64'd1);
    for (int k = 0; k < 4 && k < done_log.size(); k++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_ch = 0;
`else
      exp_ch = (k % 2 == 0) ? 1 : 0;
`endif
      check("rr_grant", 64'(done_log[k]), 64'(exp_ch));
    end
    drain();

    // Backpressure: three busy cycles delay completion by three.
    issue(0, 2'b01, 32'h104, 32'h0, 4'h0);
    stall_left = 3;
    n = 0;
    c0 = 0;
    while (n < 20 && c0 == 0) begin
      step(); n++;
      c0 = int'(ch_done[0]);
    end
    check("bp_latency", 64'(n), 64'd5);
    drain();

    // Withdrawn loser: align pointer to 0, then ch0 wins, ch1 drops.
    issue(1, 2'b10, 32'h8, 32'hA5A5A5A5, 4'hF);
    drain();
    c1 = obs_done[1];
    issue(0, 2'b01, 32'h8, 32'h0, 4'h0);
    issue(1, 2'b01, 32'hC, 32'h0, 4'h0);
    step();
    act[1] = 1'b0; flag_r[1] = 2'b00;
    drain();
    repeat (3) step();
    check("withdraw_no_done", 64'(obs_done[1] - c1), 64'd0);

    // Illegal flag 11 is never granted.
    c0 = obs_done[0];
    flag_r[0] = 2'b11;
    repeat (8) step();
    check("illegal_no_done", 64'(obs_done[0] - c0), 64'd0);
    check("illegal_idle", 64'(ch_busy), 64'd0);
    flag_r[0] = 2'b00;

    // Random traffic with random backpressure and idle-flag noise.
    rand_en = 1; noise_en = 1; rand_slave = 1;
    repeat (1500) step();
    rand_en = 0; noise_en = 0; rand_slave = 0;
    for (int i = 0; i < NUM_CH; i++) if (!act[i]) flag_r[i] = 2'b00;
    drain();

    // Asynchronous reset while a write is stalled downstream.
    issue(0, 2'b10, 32'h30, 32'hCAFEF00D, 4'hF);
    stall_left = 100;
    step(); step();
    #2 rst = 1'b0;
    #1;
    check("arst_flag", 64'(mem_rw_flag), 64'd0);
    check("arst_busy", 64'(ch_busy), 64'd0);
    check("arst_done", 64'(ch_done), 64'd0);
    check("arst_addr", 64'(mem_addr), 64'd0);
    check("arst_data", 64'(mem_write_data), 64'd0);
    check("arst_mask", 64'(mem_write_mask), 64'd0);
    check("arst_rd",   64'(ch_read_data), 64'd0);
    model_reset();
    stall_left = 0;
    mem_busy = 1'b0; mem_done = 1'b1;
    @(negedge clk) rst = 1'b1;
    issue(1, 2'b01, 32'h3C, 32'h0, 4'h0);
    n = 0;
    c1 = 0;
    while (n < 10 && c1 == 0) begin
      step(); n++;
      c1 = int'(ch_done[1]);
    end
    check("post_rst_latency", 64'(n), 64'd2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
